decode_stage_p: RTL and testbench
=================================

DECODE_STAGE_P -- requirements
Module: decode_stage_p

Interface
- REQ-001: Parameter XLEN, default 64, SHALL set the register data width.
- REQ-002: Parameter NREGS, default 32, SHALL set the register count; AW = clog2(NREGS), at least 5.
- REQ-003: Parameter ZERO_REG, default 1, SHALL make register 0 read as zero and ignore writes to it when 1.
- REQ-004: Port clk, input, 1 -- single clock; all state SHALL update on its rising edge.
- REQ-005: Port rst, input, 1 -- reset, asynchronous and active-high.
- REQ-006: Port in_valid, input, 1 -- inst is valid.
- REQ-007: Port in_ready, output, 1 -- stage accepts inst this cycle.
- REQ-008: Port inst, input, 32 -- instruction word.
- REQ-009: Port wb_en, input, 1 -- writeback strobe.
- REQ-010: Port wb_addr, input, AW -- writeback register index.
- REQ-011: Port wb_data, input, XLEN -- writeback data.
- REQ-012: Port flush, input, 1 -- discard held instruction and clear the scoreboard.
- REQ-013: Port out_valid, output, 1 -- decoded bundle is valid.
- REQ-014: Port out_ready, input, 1 -- downstream accepts the bundle.
- REQ-015: Port rs1, output, AW -- first source index, zero-extended inst[19:15].
- REQ-016: Port rs2, output, AW -- second source index, zero-extended inst[24:20].
- REQ-017: Port rd, output, AW -- destination index, zero-extended inst[11:7].
- REQ-018: Port alu_ctrl, output, 4 -- {inst[30], inst[14:12]}.
- REQ-019: Port read_data1, output, XLEN -- operand for rs1.
- REQ-020: Port read_data2, output, XLEN -- operand for rs2.

Function
- REQ-021: An accept SHALL occur when in_valid && in_ready.
- REQ-022: in_ready SHALL equal (!out_valid || out_ready) && !hazard && !flush.
- REQ-023: hazard SHALL be 1 when any of inst rs1, rs2 or rd is nonzero and its busy bit is set, unless wb_en && wb_addr equals that index in the same cycle.
- REQ-024: On accept, all output fields and operands SHALL be registered; out_valid SHALL be 1 on the next edge, giving 1-cycle latency.
- REQ-025: When out_valid && !out_ready, all outputs SHALL hold stable.
- REQ-026: When out_valid && out_ready && no accept, out_valid SHALL go to 0.
- REQ-027: The register file SHALL be written on the rising clk edge when wb_en is set; the write SHALL be ignored when wb_addr is 0 and ZERO_REG = 1.
- REQ-028: Operand capture SHALL bypass same-cycle writeback: if wb_en && wb_addr == rsN && write allowed, the operand SHALL be wb_data, else the array value.
- REQ-029: With ZERO_REG = 1, operands for index 0 SHALL be 0 regardless of the array or bypass.
- REQ-030: Scoreboard:
  - NREGS busy bits;
  - an accept with rd != 0 SHALL set busy[rd];
  - wb_en SHALL clear busy[wb_addr];
  - if set and clear hit the same index in one cycle, set wins.
- REQ-031: Flush SHALL take priority over all other events:
  - out_valid and all busy bits cleared on the next edge;
  - no accept in that cycle;
  - a register file write in that cycle still occurs.
- REQ-032: Index arithmetic SHALL be unsigned; instruction indices >= NREGS SHALL alias modulo NREGS (upper bits dropped).

Reset
- REQ-033: While rst is high, the block SHALL drive:
  - out_valid = 0;
  - rs1, rs2, rd and alu_ctrl = 0;
  - read_data1 and read_data2 = 0;
  - all busy bits = 0.
- REQ-034: Register array contents SHALL NOT be reset; reads of unwritten nonzero registers are undefined.
- REQ-035: Reset asserted mid-handshake SHALL drop the held bundle; in_ready SHALL be 1 on the first edge after release when in_valid is low.

Verification
- REQ-036: Write x5 = 0x1234 via wb, then accept inst with rs1 = 5, rs2 = 0 -> next cycle out_valid = 1, read_data1 = 0x1234, read_data2 = 0.
- REQ-037: Accept inst with rd = 7, then present inst with rs1 = 7 -> in_ready = 0 until wb_en with wb_addr = 7, wb_data = 0xAB; in that cycle accept, and read_data1 = 0xAB.
- REQ-038: out_ready = 0 for 3 cycles with out_valid = 1 -> outputs unchanged, in_ready = 0; out_ready = 1 with in_valid = 1 -> back-to-back accept.
- REQ-039: Set busy[3], then assert flush with in_valid = 1 -> in_ready = 0, out_valid = 0 next cycle, an inst reading x3 accepted the following cycle.
- REQ-040: wb_en to x0 with 0xFFFF, then read rs1 = 0 -> read_data1 = 0; same-cycle accept with rd = 9 and wb to 9 -> busy[9] = 1.

Source files
------------

// File: rtl/decode_stage_p.sv
// decode_stage_p: single-entry decode stage with register file, same-cycle
// writeback bypass and a busy-bit scoreboard that stalls on RAW/WAW hazards.
module decode_stage_p #(
    parameter int XLEN     = 64,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1,
    localparam int AW      = ($clog2(NREGS) > 5) ? $clog2(NREGS) : 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [AW-1:0]   rs1,
    output logic [AW-1:0]   rs2,
    output logic [AW-1:0]   rd,
    output logic [3:0]      alu_ctrl,
    output logic [XLEN-1:0] read_data1,
    output logic [XLEN-1:0] read_data2
);

    // Indices above NREGS-1 wrap onto the physical array.
    function automatic logic [AW-1:0] f_alias(input logic [AW-1:0] idx);
        return AW'(idx % NREGS);
    endfunction

    logic [XLEN-1:0] r_rf [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;

    logic            r_out_valid;
    logic [AW-1:0]   r_rs1, r_rs2, r_rd;
    logic [3:0]      r_alu;
    logic [XLEN-1:0] r_d1, r_d2;

    logic [AW-1:0]   w_rs1_f, w_rs2_f, w_rd_f;
    logic [AW-1:0]   w_rs1, w_rs2, w_rd, w_wa;
    logic            w_wr_ok, w_hazard, w_accept;
    logic [XLEN-1:0] w_op1, w_op2;
    logic            w_unused_bits;

    assign w_rs1_f = AW'(inst[19:15]);
    assign w_rs2_f = AW'(inst[24:20]);
    assign w_rd_f  = AW'(inst[11:7]);
    assign w_rs1   = f_alias(w_rs1_f);
    assign w_rs2   = f_alias(w_rs2_f);
    assign w_rd    = f_alias(w_rd_f);
    assign w_wa    = f_alias(wb_addr);

    // Opcode and the remaining funct7 bits are not needed by this stage.
    assign w_unused_bits = ^{inst[31], inst[29:25], inst[6:0]};

    assign w_wr_ok = wb_en && !((ZERO_REG != 0) && (w_wa == '0));

    // A busy source/destination stalls unless it is being written back right now.
    always_comb begin
        w_hazard = 1'b0;
        if (w_rs1 != '0 && r_busy[w_rs1] && !(wb_en && w_wa == w_rs1)) w_hazard = 1'b1;
        if (w_rs2 != '0 && r_busy[w_rs2] && !(wb_en && w_wa == w_rs2)) w_hazard = 1'b1;
        if (w_rd  != '0 && r_busy[w_rd]  && !(wb_en && w_wa == w_rd))  w_hazard = 1'b1;
    end

    assign in_ready = (!r_out_valid || out_ready) && !w_hazard && !flush;
    assign w_accept = in_valid && in_ready;

    // Operand read with writeback bypass; x0 forced to zero last so it wins.
    always_comb begin
        w_op1 = r_rf[w_rs1];
        w_op2 = r_rf[w_rs2];
        if (w_wr_ok && w_wa == w_rs1) w_op1 = wb_data;
        if (w_wr_ok && w_wa == w_rs2) w_op2 = wb_data;
        if ((ZERO_REG != 0) && w_rs1 == '0) w_op1 = '0;
        if ((ZERO_REG != 0) && w_rs2 == '0) w_op2 = '0;
    end

    // Scoreboard next state: writeback clears first so a same-index set wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (wb_en) w_busy_nxt[w_wa] = 1'b0;
        if (w_accept && w_rd != '0) w_busy_nxt[w_rd] = 1'b1;
    end

    // Scoreboard register; flush wipes all outstanding writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        r_busy <= '0;
        else if (flush) r_busy <= '0;
        else            r_busy <= w_busy_nxt;
    end

    // Register file: no reset, writes land even during a flush.
    always_ff @(posedge clk) begin
        if (w_wr_ok) r_rf[w_wa] <= wb_data;
    end

    // Output bundle: load on accept, hold under backpressure, drop on consume.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_alu       <= '0;
            r_d1        <= '0;
            r_d2        <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_rs1       <= w_rs1_f;
            r_rs2       <= w_rs2_f;
            r_rd        <= w_rd_f;
            r_alu       <= {inst[30], inst[14:12]};
            r_d1        <= w_op1;
            r_d2        <= w_op2;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid  = r_out_valid;
    assign rs1        = r_rs1;
    assign rs2        = r_rs2;
    assign rd         = r_rd;
    assign alu_ctrl   = r_alu;
    assign read_data1 = r_d1;
    assign read_data2 = r_d2;

endmodule

// File: tb/tb_decode_stage_p.sv
// Testbench for decode_stage_p: directed scenarios plus a randomized run
// against a behavioural model of the stage.
module tb_decode_stage_p;
    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     inst = '0;
    logic            wb_en = 1'b0;
    logic [AW-1:0]   wb_addr = '0;
    logic [XLEN-1:0] wb_data = '0;
    logic            flush = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [AW-1:0]   rs1, rs2, rd;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] read_data1, read_data2;

    int checks = 0;
    int errors = 0;

    decode_stage_p #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .rs1(rs1), .rs2(rs2), .rd(rd), .alu_ctrl(alu_ctrl),
        .read_data1(read_data1), .read_data2(read_data2)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [XLEN-1:0] m_rf [NREGS];
    logic [NREGS-1:0] m_busy = '0;
    logic            m_ov = 1'b0;
    logic [AW-1:0]   m_rs1 = '0, m_rs2 = '0, m_rd = '0;
    logic [3:0]      m_alu = '0;
    logic [XLEN-1:0] m_d1 = '0, m_d2 = '0;

    function automatic logic [31:0] mk(input logic [4:0] a, input logic [4:0] b,
                                       input logic [4:0] d, input logic [2:0] f3,
                                       input logic b30);
        logic [31:0] w;
        w = 32'h33;
        w[19:15] = a;
        w[24:20] = b;
        w[11:7]  = d;
        w[14:12] = f3;
        w[30]    = b30;
        return w;
    endfunction

    function automatic logic m_ready();
        logic [4:0] ix [3];
        logic haz;
        ix[0] = inst[19:15];
        ix[1] = inst[24:20];
        ix[2] = inst[11:7];
        haz = 1'b0;
        for (int k = 0; k < 3; k++)
            if (ix[k] != 0 && m_busy[ix[k]] && !(wb_en && wb_addr == ix[k])) haz = 1'b1;
        return (!m_ov || out_ready) && !haz && !flush;
    endfunction

    function automatic logic [XLEN-1:0] m_op(input logic [4:0] idx);
        if (idx == 0) return '0;
        if (wb_en && wb_addr == idx) return wb_data;
        return m_rf[idx];
    endfunction

    task automatic m_reset();
        m_ov = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_alu = 0; m_d1 = 0; m_d2 = 0;
        m_busy = '0;
    endtask

    task automatic drive(input logic iv, input logic [31:0] ins, input logic we,
                         input logic [4:0] wa, input logic [XLEN-1:0] wd,
                         input logic fl, input logic ordy);
        in_valid = iv; inst = ins; wb_en = we; wb_addr = wa; wb_data = wd;
        flush = fl; out_ready = ordy;
    endtask

    // One clock: evaluate the model on the pre-edge inputs, then advance it.
    task automatic cyc();
        logic acc;
        logic [XLEN-1:0] o1, o2;
        acc = in_valid && m_ready();
        o1  = m_op(inst[19:15]);
        o2  = m_op(inst[24:20]);
        @(posedge clk);
        if (flush) begin
            m_ov = 0;
            m_busy = '0;
        end else begin
            if (acc) begin
                m_ov = 1; m_rs1 = inst[19:15]; m_rs2 = inst[24:20]; m_rd = inst[11:7];
                m_alu = {inst[30], inst[14:12]}; m_d1 = o1; m_d2 = o2;
            end else if (out_ready) m_ov = 0;
            if (wb_en) m_busy[wb_addr] = 0;
            if (acc && inst[11:7] != 0) m_busy[inst[11:7]] = 1;
        end
        if (wb_en && wb_addr != 0) m_rf[wb_addr] = wb_data;
        #1;
    endtask

    task automatic drain();
        drive(0, '0, 0, '0, '0, 0, 1);
        cyc();
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({out_valid, rs1, rs2, rd, alu_ctrl, read_data1, read_data2} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ov=%b rs1=%0d rs2=%0d rd=%0d alu=%h d1=%h d2=%h, want all 0",
                     out_valid, rs1, rs2, rd, alu_ctrl, read_data1, read_data2);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        m_reset();
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i < NREGS; i++) begin
            drive(0, '0, 1, 5'(i), {$urandom, $urandom}, 0, 1);
            cyc();
        end
        drive(0, mk(1, 2, 3, 0, 0), 0, '0, '0, 0, 1);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL fill_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_bypass_zero();
        drive(0, '0, 1, 5'd5, 64'h1234, 0, 1);
        cyc();
        drive(1, mk(5, 0, 0, 3'd2, 0), 0, '0, '0, 0, 1);
        cyc();
        checks++;
        if (out_valid !== 1'b1 || read_data1 !== 64'h1234 || read_data2 !== '0) begin
            errors++;
            $display("FAIL bypass_x5: got ov=%b d1=%h d2=%h want ov=1 d1=1234 d2=0",
                     out_valid, read_data1, read_data2);
        end
        drain();
    endtask

    task automatic test_hazard();
        drive(1, mk(0, 0, 7, 0, 0), 0, '0, '0, 0, 1);
        cyc();
        drive(1, mk(7, 0, 0, 0, 0), 0, '0, '0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++; $display("FAIL hazard_stall: cycle %0d got in_ready=%b want 0", i, in_ready);
            end
            cyc();
        end
        drive(1, mk(7, 0, 0, 0, 0), 1, 5'd7, 64'hAB, 0, 1);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL hazard_release: got in_ready=%b want 1", in_ready);
        end
        cyc();
        checks++;
        if (out_valid !== 1'b1 || read_data1 !== 64'hAB) begin
            errors++; $display("FAIL hazard_bypass: got ov=%b d1=%h want ov=1 d1=ab", out_valid, read_data1);
        end
        drain();
    endtask

    task automatic test_stall();
        drive(1, mk(2, 3, 0, 3'd5, 1), 0, '0, '0, 0, 1);
        cyc();
        drive(1, mk(4, 6, 0, 3'd1, 0), 0, '0, '0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || rs1 !== 5'd2 || rs2 !== 5'd3 ||
                alu_ctrl !== 4'hD || read_data1 !== m_rf[2] || read_data2 !== m_rf[3]) begin
                errors++;
                $display("FAIL stall_hold: cycle %0d got rdy=%b ov=%b rs1=%0d rs2=%0d alu=%h want rdy=0 ov=1 rs1=2 rs2=3 alu=d",
                         i, in_ready, out_valid, rs1, rs2, alu_ctrl);
            end
            cyc();
        end
        drive(1, mk(4, 6, 0, 3'd1, 0), 0, '0, '0, 0, 1);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL stall_resume: got in_ready=%b want 1", in_ready);
        end
        cyc();
        checks++;
        if (out_valid !== 1'b1 || rs1 !== 5'd4 || rs2 !== 5'd6 || alu_ctrl !== 4'h1) begin
            errors++; $display("FAIL b2b_first: got ov=%b rs1=%0d rs2=%0d alu=%h want 1/4/6/1",
                               out_valid, rs1, rs2, alu_ctrl);
        end
        drive(1, mk(8, 9, 0, 3'd7, 1), 0, '0, '0, 0, 1);
        cyc();
        checks++;
        if (out_valid !== 1'b1 || rs1 !== 5'd8 || read_data2 !== m_rf[9] || alu_ctrl !== 4'hF) begin
            errors++; $display("FAIL b2b_second: got ov=%b rs1=%0d alu=%h want ov=1 rs1=8 alu=f",
                               out_valid, rs1, alu_ctrl);
        end
        drain();
    endtask

    task automatic test_flush();
        drive(1, mk(0, 0, 3, 0, 0), 0, '0, '0, 0, 1);
        cyc();
        drive(1, mk(3, 0, 0, 0, 0), 0, '0, '0, 1, 1);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL flush_in_ready: got %b want 0", in_ready);
        end
        cyc();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_out_valid: got %b want 0", out_valid);
        end
        drive(1, mk(3, 0, 0, 0, 0), 0, '0, '0, 0, 1);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_busy_clear: got in_ready=%b want 1", in_ready);
        end
        cyc();
        checks++;
        if (out_valid !== 1'b1 || rs1 !== 5'd3 || read_data1 !== m_rf[3]) begin
            errors++; $display("FAIL flush_after: got ov=%b rs1=%0d want ov=1 rs1=3", out_valid, rs1);
        end
        drain();
    endtask

    task automatic test_x0();
        drive(0, '0, 1, 5'd0, 64'hFFFF, 0, 1);
        cyc();
        drive(1, mk(0, 0, 9, 0, 0), 1, 5'd9, 64'h77, 0, 1);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL x0_in_ready: got %b want 1", in_ready);
        end
        cyc();
        checks++;
        if (out_valid !== 1'b1 || read_data1 !== '0) begin
            errors++; $display("FAIL x0_read: got ov=%b d1=%h want ov=1 d1=0", out_valid, read_data1);
        end
        drive(1, mk(9, 0, 0, 0, 0), 0, '0, '0, 0, 1);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL set_wins: got in_ready=%b want 0 (busy[9] set)", in_ready);
        end
        drive(1, mk(9, 0, 0, 0, 0), 1, 5'd9, 64'h55, 0, 1);
        cyc();
        checks++;
        if (out_valid !== 1'b1 || read_data1 !== 64'h55) begin
            errors++; $display("FAIL x9_bypass: got ov=%b d1=%h want ov=1 d1=55", out_valid, read_data1);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        drive(1, mk(1, 2, 4, 3'd3, 1), 0, '0, '0, 0, 1);
        cyc();
        drive(0, '0, 0, '0, '0, 0, 0);
        cyc();
        rst = 1'b1;
        m_reset();
        #1;
        checks++;
        if ({out_valid, rs1, rs2, rd, alu_ctrl, read_data1, read_data2} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got ov=%b rs1=%0d rd=%0d alu=%h d1=%h want all 0",
                     out_valid, rs1, rd, alu_ctrl, read_data1);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, mk(4, 0, 0, 0, 0), 0, '0, '0, 0, 0);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_mid_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_random();
        logic [31:0] w;
        for (int n = 0; n < 400; n++) begin
            w = $urandom;
            w[19:15] = 5'($urandom_range(0, 7));
            w[24:20] = 5'($urandom_range(0, 7));
            w[11:7]  = 5'($urandom_range(0, 7));
            drive(($urandom_range(0, 9) < 7), w, ($urandom_range(0, 9) < 4),
                  5'($urandom_range(0, 7)), {$urandom, $urandom},
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7));
            #1;
            checks++;
            if (in_ready !== m_ready()) begin
                errors++; $display("FAIL rand_in_ready: iter %0d got %b want %b", n, in_ready, m_ready());
            end
            cyc();
            checks++;
            if ({out_valid, rs1, rs2, rd, alu_ctrl, read_data1, read_data2} !==
                {m_ov, m_rs1, m_rs2, m_rd, m_alu, m_d1, m_d2}) begin
                errors++;
                $display("FAIL rand_bundle: iter %0d got ov=%b rs1=%0d rs2=%0d rd=%0d alu=%h d1=%h d2=%h want ov=%b rs1=%0d rs2=%0d rd=%0d alu=%h d1=%h d2=%h",
                         n, out_valid, rs1, rs2, rd, alu_ctrl, read_data1, read_data2,
                         m_ov, m_rs1, m_rs2, m_rd, m_alu, m_d1, m_d2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_bypass_zero();
        test_hazard();
        test_stall();
        test_flush();
        test_x0();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
